// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives a synchronous-read ROM and hands a registered
// instruction word, its PC and a valid flag to decode. Handles branch redirect, stall and halt.
module fetch_unit #(
  parameter int unsigned          PC_W       = 10,
  parameter int unsigned          INSTR_W    = 9,
  parameter logic [PC_W-1:0]      START_ADDR = '0,
  parameter logic [INSTR_W-1:0]   HALT_CODE  = 9'h1FF
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic               Stall,
  input  logic               BrTaken,
  input  logic [5:0]         BImmed,
  output logic [PC_W-1:0]    Imem_addr,
  output logic               Imem_en,
  input  logic [INSTR_W-1:0] Imem_rdata,
  output logic [INSTR_W-1:0] Mach_code,
  output logic               Instr_valid,
  output logic [PC_W-1:0]    PC_out,
  output logic               Done
);

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    fpc_q, fpc_d;
  logic [PC_W-1:0]    dpc_q, dpc_d;
  logic               dvalid_q, dvalid_d;
  logic [INSTR_W-1:0] mach_q, mach_d;
  logic [PC_W-1:0]    pc_out_q, pc_out_d;
  logic               ivalid_q, ivalid_d;
  logic               done_q, done_d;
  logic [PC_W-1:0]    br_off;
  logic               imem_en;

  assign br_off = {{(PC_W-6){BImmed[5]}}, BImmed};

  always_comb begin
    state_d  = state_q;
    fpc_d    = fpc_q;
    dpc_d    = dpc_q;
    dvalid_d = dvalid_q;
    mach_d   = mach_q;
    pc_out_d = pc_out_q;
    ivalid_d = ivalid_q;
    done_d   = done_q;
    imem_en  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (Start) begin
          fpc_d    = START_ADDR;
          dvalid_d = 1'b0;
          state_d  = StRun;
        end
      end
      StRun: begin
        if (!Stall) begin
          imem_en  = 1'b1;
          fpc_d    = fpc_q + PC_W'(1);
          dpc_d    = fpc_q;
          dvalid_d = 1'b1;
          mach_d   = Imem_rdata;
          pc_out_d = dpc_q;
          ivalid_d = dvalid_q;
          if (ivalid_q && (mach_q == HALT_CODE)) begin
            // Freeze the pipeline with the halt word still on Mach_code, but no longer valid.
            fpc_d    = fpc_q;
            dpc_d    = dpc_q;
            mach_d   = mach_q;
            pc_out_d = pc_out_q;
            dvalid_d = 1'b0;
            ivalid_d = 1'b0;
            done_d   = 1'b1;
            state_d  = StHalt;
          end else if (ivalid_q && BrTaken) begin
            // Squash both younger words; target reaches decode after two bubbles.
            fpc_d    = pc_out_q + br_off;
            dvalid_d = 1'b0;
            ivalid_d = 1'b0;
          end
        end
      end
      StHalt: begin
        if (Start) begin
          done_d   = 1'b0;
          fpc_d    = START_ADDR;
          dvalid_d = 1'b0;
          state_d  = StRun;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= StIdle;
      fpc_q    <= START_ADDR;
      dpc_q    <= '0;
      dvalid_q <= 1'b0;
      mach_q   <= '0;
      pc_out_q <= '0;
      ivalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      fpc_q    <= fpc_d;
      dpc_q    <= dpc_d;
      dvalid_q <= dvalid_d;
      mach_q   <= mach_d;
      pc_out_q <= pc_out_d;
      ivalid_q <= ivalid_d;
      done_q   <= done_d;
    end
  end

  assign Imem_addr   = fpc_q;
  assign Imem_en     = imem_en;
  assign Mach_code   = mach_q;
  assign Instr_valid = ivalid_q;
  assign PC_out      = pc_out_q;
  assign Done        = done_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural ROM, expected {PC, code} scoreboard popped whenever a new
// valid instruction reaches decode, plus per-scenario timing checks.
module tb_fetch_unit;
  localparam int unsigned PC_W = 10;
  localparam int unsigned INSTR_W = 9;

  logic               Clk = 1'b0;
  logic               Reset = 1'b1;
  logic               Start = 1'b0;
  logic               Stall = 1'b0;
  logic               BrTaken = 1'b0;
  logic [5:0]         BImmed = '0;
  logic [PC_W-1:0]    Imem_addr;
  logic               Imem_en;
  logic [INSTR_W-1:0] Imem_rdata = '0;
  logic [INSTR_W-1:0] Mach_code;
  logic               Instr_valid;
  logic [PC_W-1:0]    PC_out;
  logic               Done;

  logic [INSTR_W-1:0] rom [1024];
  logic [18:0]        exp_q [$];
  logic               adv = 1'b0;
  int                 n_tests = 0;
  int                 n_fail = 0;

  fetch_unit dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .Stall      (Stall),
    .BrTaken    (BrTaken),
    .BImmed     (BImmed),
    .Imem_addr  (Imem_addr),
    .Imem_en    (Imem_en),
    .Imem_rdata (Imem_rdata),
    .Mach_code  (Mach_code),
    .Instr_valid(Instr_valid),
    .PC_out     (PC_out),
    .Done       (Done)
  );

  always #5 Clk = ~Clk;

  // Synchronous-read ROM; adv marks edges at which decode may receive a new word.
  always @(posedge Clk) begin
    if (Imem_en) Imem_rdata <= rom[Imem_addr];
    adv <= !Stall;
  end

  always @(negedge Clk) begin
    if (!Reset && Instr_valid && adv) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_extra: got pc=%0d code=%h, expected no instruction", PC_out,
                 Mach_code);
      end else begin
        logic [18:0] e;
        e = exp_q.pop_front();
        if ({PC_out, Mach_code} !== e) begin
          n_fail++;
          $display("FAIL scoreboard: got pc=%0d code=%h, expected pc=%0d code=%h", PC_out,
                   Mach_code, e[18:9], e[8:0]);
        end
      end
    end
  end

  task automatic fill_rom();
    for (int i = 0; i < 1024; i++) rom[i] = 9'((i * 37 + 11) % 256);
  endtask

  task automatic push_exp(input int pc);
    logic [PC_W-1:0] p;
    p = PC_W'(pc);
    exp_q.push_back({p, rom[p]});
  endtask

  task automatic hard_reset();
    Reset = 1'b1;
    Start = 1'b0;
    Stall = 1'b0;
    BrTaken = 1'b0;
    @(negedge Clk);
    #1;
    Reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic start_pulse();
    @(negedge Clk);
    #1;
    Start = 1'b1;
    @(negedge Clk);
    #1;
    Start = 1'b0;
  endtask

  task automatic wait_pc(input int pc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge Clk);
      #1;
      if (Instr_valid && (PC_out == PC_W'(pc))) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge Clk);
      #1;
    end
  endtask

  // Counts invalid cycles after a branch edge; releases BrTaken on the first one.
  task automatic count_bubbles(output int bub);
    bub = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      #1;
      BrTaken = 1'b0;
      if (Instr_valid) break;
      bub++;
    end
  endtask

  task automatic test_reset();
    #1;
    n_tests++;
    if ({Mach_code, PC_out, Instr_valid, Done, Imem_en, Imem_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got code=%h pc=%0d v=%b done=%b en=%b addr=%0d, expected all 0",
               Mach_code, PC_out, Instr_valid, Done, Imem_en, Imem_addr);
    end
  endtask

  task automatic test_basic_halt();
    bit ok;
    fill_rom();
    rom[0] = 9'h041; rom[1] = 9'h0C4; rom[2] = 9'h182; rom[3] = 9'h1FF;
    hard_reset();
    for (int i = 0; i < 4; i++) push_exp(i);
    start_pulse();
    @(negedge Clk); #1;
    n_tests++;
    if (Instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL latency_early: got valid=%b, expected 0", Instr_valid);
    end
    @(negedge Clk); #1;
    n_tests++;
    if (Instr_valid !== 1'b1 || PC_out !== '0) begin
      n_fail++;
      $display("FAIL latency_first: got valid=%b pc=%0d, expected 1/0", Instr_valid, PC_out);
    end
    wait_pc(3, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL halt_word_seen: got timeout, expected pc 3"); end
    @(negedge Clk); #1;
    n_tests++;
    if (Done !== 1'b1 || Instr_valid !== 1'b0 || Imem_en !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_done: got done=%b v=%b en=%b, expected 1/0/0", Done, Instr_valid,
               Imem_en);
    end
    repeat (3) @(negedge Clk);
    #1;
    n_tests++;
    if (Done !== 1'b1 || Instr_valid !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL halt_hold: got done=%b v=%b left=%0d, expected 1/0/0", Done, Instr_valid,
               exp_q.size());
    end
  endtask

  task automatic test_branch();
    bit ok;
    int bub;
    fill_rom();
    hard_reset();
    for (int i = 0; i < 6; i++) push_exp(i);
    start_pulse();
    wait_pc(5, ok);
    BrTaken = 1'b1; BImmed = 6'b111101;
    for (int i = 2; i < 6; i++) push_exp(i);
    count_bubbles(bub);
    n_tests++;
    if (!ok || bub != 2 || PC_out !== 10'd2) begin
      n_fail++;
      $display("FAIL branch_back: got ok=%b bubbles=%0d pc=%0d, expected 1/2/2", ok, bub,
               PC_out);
    end
    wait_pc(5, ok);
    BrTaken = 1'b1; BImmed = 6'd31;
    for (int i = 36; i < 39; i++) push_exp(i);
    count_bubbles(bub);
    n_tests++;
    if (!ok || bub != 2 || PC_out !== 10'd36) begin
      n_fail++;
      $display("FAIL branch_fwd: got ok=%b bubbles=%0d pc=%0d, expected 1/2/36", ok, bub, PC_out);
    end
    drain(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL branch_drain: got timeout, expected empty queue"); end
  endtask

  task automatic test_stall();
    bit ok;
    int bad;
    fill_rom();
    hard_reset();
    for (int i = 0; i < 8; i++) push_exp(i);
    start_pulse();
    wait_pc(7, ok);
    Stall = 1'b1; BrTaken = 1'b1; BImmed = 6'b111101;
    bad = 0;
    repeat (3) begin
      @(negedge Clk); #1;
      if (PC_out !== 10'd7 || Mach_code !== rom[7] || Imem_addr !== 10'd9 || Imem_en !== 1'b0 ||
          Instr_valid !== 1'b1) bad++;
    end
    n_tests++;
    if (!ok || bad != 0) begin
      n_fail++;
      $display("FAIL stall_hold: got ok=%b bad_cycles=%0d pc=%0d addr=%0d en=%b, expected 1/0/7/9/0",
               ok, bad, PC_out, Imem_addr, Imem_en);
    end
    Stall = 1'b0; BrTaken = 1'b0;
    for (int i = 8; i < 11; i++) push_exp(i);
    @(negedge Clk); #1;
    n_tests++;
    if (Instr_valid !== 1'b1 || PC_out !== 10'd8) begin
      n_fail++;
      $display("FAIL stall_release: got v=%b pc=%0d, expected 1/8", Instr_valid, PC_out);
    end
    drain(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL stall_drain: got timeout, expected empty queue"); end
  endtask

  task automatic test_wrap();
    bit ok;
    int bub;
    fill_rom();
    hard_reset();
    push_exp(0); push_exp(1);
    start_pulse();
    wait_pc(1, ok);
    BrTaken = 1'b1; BImmed = 6'b111100;
    push_exp(1021); push_exp(1022); push_exp(1023); push_exp(0); push_exp(1);
    count_bubbles(bub);
    n_tests++;
    if (!ok || bub != 2 || PC_out !== 10'd1021) begin
      n_fail++;
      $display("FAIL wrap_branch: got ok=%b bubbles=%0d pc=%0d, expected 1/2/1021", ok, bub,
               PC_out);
    end
    drain(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL wrap_drain: got timeout, expected empty queue"); end
  endtask

  task automatic test_reset_mid_bubble();
    bit ok;
    fill_rom();
    hard_reset();
    for (int i = 0; i < 6; i++) push_exp(i);
    start_pulse();
    wait_pc(5, ok);
    BrTaken = 1'b1; BImmed = 6'b111101;
    @(negedge Clk); #1;
    BrTaken = 1'b0;
    #1;
    Reset = 1'b1;
    #1;
    n_tests++;
    if (!ok || {Mach_code, PC_out, Instr_valid, Done, Imem_en, Imem_addr} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got code=%h pc=%0d v=%b done=%b en=%b addr=%0d, expected 0",
               Mach_code, PC_out, Instr_valid, Done, Imem_en, Imem_addr);
    end
    exp_q.delete();
    @(negedge Clk); #1;
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    #1;
    n_tests++;
    if (Imem_en !== 1'b0 || Instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got en=%b v=%b, expected 0/0", Imem_en, Instr_valid);
    end
    for (int i = 0; i < 3; i++) push_exp(i);
    start_pulse();
    drain(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL refetch_drain: got timeout, expected empty queue"); end
  endtask

  task automatic test_halt_shadow();
    bit ok;
    int bub;
    int done_seen;
    fill_rom();
    rom[6] = 9'h1FF;
    hard_reset();
    for (int i = 0; i < 6; i++) push_exp(i);
    start_pulse();
    wait_pc(5, ok);
    BrTaken = 1'b1; BImmed = 6'b111101;
    for (int i = 2; i < 7; i++) push_exp(i);
    done_seen = 0;
    bub = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk); #1;
      BrTaken = 1'b0;
      if (Done) done_seen++;
      if (Instr_valid) break;
      bub++;
    end
    n_tests++;
    if (!ok || bub != 2 || done_seen != 0 || PC_out !== 10'd2) begin
      n_fail++;
      $display("FAIL shadow_no_halt: got ok=%b bubbles=%0d done_cycles=%0d pc=%0d, expected 1/2/0/2",
               ok, bub, done_seen, PC_out);
    end
    wait_pc(6, ok);
    BrTaken = 1'b1; BImmed = 6'd31;
    @(negedge Clk); #1;
    BrTaken = 1'b0;
    n_tests++;
    if (!ok || Done !== 1'b1 || Instr_valid !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL halt_over_branch: got ok=%b done=%b v=%b left=%0d, expected 1/1/0/0", ok,
               Done, Instr_valid, exp_q.size());
    end
    repeat (3) @(negedge Clk);
    #1;
    n_tests++;
    if (Imem_en !== 1'b0 || Instr_valid !== 1'b0 || Done !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_idle: got en=%b v=%b done=%b, expected 0/0/1", Imem_en, Instr_valid,
               Done);
    end
    for (int i = 0; i < 6; i++) push_exp(i);
    start_pulse();
    n_tests++;
    if (Done !== 1'b0 || Imem_addr !== '0) begin
      n_fail++;
      $display("FAIL restart_from_halt: got done=%b addr=%0d, expected 0/0", Done, Imem_addr);
    end
    drain(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL restart_drain: got timeout, expected empty queue"); end
  endtask

  initial begin
    fill_rom();
    test_reset();
    test_basic_halt();
    test_branch();
    test_stall();
    test_wrap();
    test_reset_mid_bubble();
    test_halt_shadow();
    hard_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit reached, expected bench completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the 9-bit instruction decoder.
- Owns the program counter and drives a synchronous-read instruction ROM.
- Presents a registered machine code word to decode, with a valid flag and the instruction's PC.
- Applies PC-relative branch redirects, stalls, and start/halt control.

Parameters:
PC_W, 10, program counter / ROM address width (1024-entry program memory)
INSTR_W, 9, instruction width
START_ADDR, 0, PC loaded on Start
HALT_CODE, 9'h1FF, machine code that terminates the program (opcode 3'b111, otherwise unused by decode)

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
Start  in  1  single-cycle pulse; begins fetching at START_ADDR
Stall  in  1  hold the current instruction and all fetch state
BrTaken  in  1  branch resolved taken for the instruction now on Mach_code
BImmed  in  6  signed branch offset (two's complement) relative to PC_out
Imem_addr  out  PC_W  ROM read address (= fetch PC register)
Imem_en  out  1  ROM read enable; ROM output updates only at edges where Imem_en=1
Imem_rdata  in  INSTR_W  ROM data; valid one cycle after an enabled address
Mach_code  out  INSTR_W  registered instruction to decode
Instr_valid  out  1  Mach_code is a live instruction
PC_out  out  PC_W  address of Mach_code
Done  out  1  program reached HALT_CODE

Behaviour:
- States: IDLE, RUN, HALT.
- Internal registers:
  - fpc: fetch PC, drives Imem_addr.
  - dpc / dvalid: address and validity of the ROM word in flight.
- Reset (async, any time, including mid-branch or mid-stall): state=IDLE, fpc=START_ADDR, dvalid=0, Mach_code=0, Instr_valid=0, PC_out=0, Done=0. Imem_en=0 while not in RUN.
- IDLE:
  - Start=1 → fpc<=START_ADDR, dvalid<=0, state<=RUN.
  - All other inputs are ignored.
- RUN, Stall=0, no redirect:
  - fpc<=fpc+1, dpc<=fpc, dvalid<=1.
  - Mach_code<=Imem_rdata, PC_out<=dpc, Instr_valid<=dvalid.
  - Imem_en=1.
- Latency: START_ADDR is presented in the first RUN cycle. Its instruction appears on Mach_code with Instr_valid=1 two edges later. Throughput is then 1 instruction per cycle.
- Stall=1 in RUN:
  - Imem_en=0; fpc, dpc, dvalid, Mach_code, PC_out and Instr_valid all hold.
  - BrTaken is ignored. Decode reasserts it after the stall clears.
  - Stall has priority over redirect and halt.
- Branch (RUN, Stall=0, Instr_valid=1, BrTaken=1):
  - fpc<=PC_out+sext(BImmed), computed modulo 2^PC_W.
  - dvalid<=0, Instr_valid<=0. Squashes the two younger instructions, giving exactly 2 bubble cycles.
  - The target instruction appears on Mach_code on the 3rd edge after the branch edge.
  - BrTaken with Instr_valid=0 is ignored.
- Halt (RUN, Stall=0, Instr_valid=1, Mach_code==HALT_CODE):
  - state<=HALT, Done<=1, Instr_valid<=0, dvalid<=0.
  - Halt wins over a simultaneous BrTaken.
- HALT:
  - Imem_en=0, all registers hold, Done=1.
  - Start=1 → Done<=0, fpc<=START_ADDR, dvalid<=0, state<=RUN.
- Start while in RUN: ignored.
- Wrap-around: fpc increments from 2^PC_W-1 to 0. Branch targets wrap modulo 2^PC_W in both directions.
- Squashed words are never presented valid. HALT_CODE sitting in a squashed slot does not halt.

Test Plan:
- Reset, Start, ROM[0..3]={9'h041,9'h0C4,9'h182,9'h1FF} → Mach_code 041/0C4/182 valid on consecutive cycles. PC_out 0/1/2. Done=1 one edge after 1FF is presented. Instr_valid=0 thereafter.
- At PC_out=5, BrTaken=1, BImmed=-3 (6'b111101) → 2 invalid cycles, then PC_out=2 with ROM[2]. Repeat with BImmed=+31 → PC_out=36.
- Stall high for 3 cycles at PC_out=7 → Mach_code, PC_out and Imem_addr frozen, Imem_en=0. After release, PC_out=8 follows with no loss or duplication.
- Branch with PC_out=1, BImmed=-4 → next valid PC_out=1021 (wrap). Sequential fetch from 1023 → PC_out 1023 then 0.
- Reset asserted mid-branch-bubble → outputs zero immediately (async), state IDLE. A new Start refetches from START_ADDR.
- HALT_CODE placed in the branch shadow at PC 6, branch taken at PC 5 → no halt, Done=0. Start issued in HALT → Done clears and fetch restarts at 0.
